alpha_col_packer: RTL and testbench

ALPHA_COL_PACKER -- requirements
Module: alpha_col_packer

---
 rtl/alpha_col_packer_pkg.sv | 19 +
 rtl/alpha_col_packer.sv | 128 ++++++++++++
 tb/tb_alpha_col_packer.sv | 284 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alpha_col_packer_pkg.sv
// Shared constants for the double-precision datapath and the column
// packer state encoding.
package alpha_col_packer_pkg;

  // Width of one IEEE-754 double on the stream.
  localparam int DBL_W = 64;

  // Default column geometry: doubles per alpha column, columns per frame.
  localparam int J_DEF = 14;
  localparam int I_DEF = 2;

  // FILL: collecting doubles 0..J-2 into the accumulator.
  // LAST: waiting to accept double J-1, gated by the output slot.
  typedef enum logic {
    ST_FILL = 1'b0,
    ST_LAST = 1'b1
  } pack_state_e;

endpackage

// File: rtl/alpha_col_packer.sv
// Packs a stream of doubles into J-wide alpha columns, I columns per frame.
// The first double of a column lands in the most significant slot.
// Handshake: a beat moves on either port at a rising edge where valid and
// ready are both high; valid, data and last hold steady until that edge.
module alpha_col_packer
  import alpha_col_packer_pkg::*;
#(
  parameter int J = J_DEF,
  parameter int I = I_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [DBL_W-1:0]     s_tdata,
  input  logic                 s_tvalid,
  output logic                 s_tready,
  input  logic                 s_tlast,
  output logic [J*DBL_W-1:0]   alpha_u_col,
  output logic                 alpha_u_col_tvalid,
  input  logic                 alpha_u_col_tready,
  output logic                 alpha_u_col_tlast,
  output logic                 frame_err
);

  localparam int J_WIDTH = $clog2(J) + 1;
  localparam int I_WIDTH = $clog2(I) + 1;
  localparam int ACC_W   = (J - 1) * DBL_W;

  pack_state_e          state_q, state_d;
  logic [J_WIDTH-1:0]   elem_cnt_q, elem_cnt_d;
  logic [I_WIDTH-1:0]   col_cnt_q, col_cnt_d;
  logic [ACC_W-1:0]     acc_q, acc_d;
  logic [J*DBL_W-1:0]   col_q, col_d;
  logic                 col_vld_q, col_vld_d;
  logic                 col_last_q, col_last_d;
  logic                 ferr_q, ferr_d;

  logic accept;
  logic at_last_col;

  assign accept      = s_tvalid && s_tready;
  assign at_last_col = (col_cnt_q == I_WIDTH'(I - 1));

  // Next-state, accumulator, output-slot and framing-error logic.
  always_comb begin
    state_d    = state_q;
    elem_cnt_d = elem_cnt_q;
    col_cnt_d  = col_cnt_q;
    acc_d      = acc_q;
    col_d      = col_q;
    // A handshake frees the slot; a load below overrides this.
    col_vld_d  = col_vld_q && !alpha_u_col_tready;
    col_last_d = col_last_q && !alpha_u_col_tready;
    ferr_d     = 1'b0;
    s_tready   = 1'b1;

    case (state_q)
      ST_FILL: begin
        s_tready = 1'b1;
        if (accept) begin
          if (s_tlast) begin
            // Early end of frame: drop the partial column and resync.
            elem_cnt_d = '0;
            col_cnt_d  = '0;
            ferr_d     = 1'b1;
          end else begin
            acc_d[(J - 2 - int'(elem_cnt_q)) * DBL_W +: DBL_W] = s_tdata;
            elem_cnt_d = elem_cnt_q + J_WIDTH'(1);
            if (elem_cnt_q == J_WIDTH'(J - 2)) begin
              state_d = ST_LAST;
            end
          end
        end
      end
      ST_LAST: begin
        // The final double completes the column, so it may only be taken
        // when the output slot is free or draining this cycle.
        s_tready = !col_vld_q || alpha_u_col_tready;
        if (accept) begin
          state_d    = ST_FILL;
          elem_cnt_d = '0;
          if (s_tlast && !at_last_col) begin
            col_cnt_d = '0;
            ferr_d    = 1'b1;
          end else begin
            col_d      = {acc_q, s_tdata};
            col_vld_d  = 1'b1;
            col_last_d = at_last_col;
            col_cnt_d  = at_last_col ? '0 : col_cnt_q + I_WIDTH'(1);
            // Missing tlast on the last column still closes the frame.
            ferr_d     = at_last_col && !s_tlast;
          end
        end
      end
      default: begin
        state_d = ST_FILL;
      end
    endcase
  end

  // State, counters, accumulator and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_FILL;
      elem_cnt_q <= '0;
      col_cnt_q  <= '0;
      acc_q      <= '0;
      col_q      <= '0;
      col_vld_q  <= 1'b0;
      col_last_q <= 1'b0;
      ferr_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      elem_cnt_q <= elem_cnt_d;
      col_cnt_q  <= col_cnt_d;
      acc_q      <= acc_d;
      col_q      <= col_d;
      col_vld_q  <= col_vld_d;
      col_last_q <= col_last_d;
      ferr_q     <= ferr_d;
    end
  end

  assign alpha_u_col        = col_q;
  assign alpha_u_col_tvalid = col_vld_q;
  assign alpha_u_col_tlast  = col_last_q;
  assign frame_err          = ferr_q;

endmodule

// File: tb/tb_alpha_col_packer.sv
// Bench for alpha_col_packer: directed framing scenarios plus a random
// valid/ready soak, with packed columns checked against a queue.
module tb_alpha_col_packer;

  localparam int J     = 14;
  localparam int I     = 2;
  localparam int EXP_W = J * 64 + 1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [63:0]     s_tdata = '0;
  logic            s_tvalid = 1'b0;
  logic            s_tready;
  logic            s_tlast = 1'b0;
  logic [J*64-1:0] alpha_u_col;
  logic            alpha_u_col_tvalid;
  logic            alpha_u_col_tready = 1'b1;
  logic            alpha_u_col_tlast;
  logic            frame_err;

  alpha_col_packer #(.J(J), .I(I)) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .s_tdata            (s_tdata),
    .s_tvalid           (s_tvalid),
    .s_tready           (s_tready),
    .s_tlast            (s_tlast),
    .alpha_u_col        (alpha_u_col),
    .alpha_u_col_tvalid (alpha_u_col_tvalid),
    .alpha_u_col_tready (alpha_u_col_tready),
    .alpha_u_col_tlast  (alpha_u_col_tlast),
    .frame_err          (frame_err)
  );

  // ---------------- checking ----------------
  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model / scoreboard ----------------
  logic [EXP_W-1:0]    exp_q[$];
  logic [(J-1)*64-1:0] m_acc = '0;
  int m_k = 0;
  int m_c = 0;
  int fe_exp = 0;
  int fe_seen = 0;

  task automatic model_accept(input logic [63:0] d, input logic last);
    if (m_k == J - 1) begin
      if (m_c == I - 1) begin
        exp_q.push_back({1'b1, m_acc, d});
        if (!last) fe_exp++;
        m_c = 0;
      end else if (last) begin
        fe_exp++;
        m_c = 0;
      end else begin
        exp_q.push_back({1'b0, m_acc, d});
        m_c++;
      end
      m_k = 0;
    end else if (last) begin
      fe_exp++;
      m_k = 0;
      m_c = 0;
    end else begin
      m_acc[(J - 2 - m_k) * 64 +: 64] = d;
      m_k++;
    end
  endtask

  // ---------------- drivers ----------------
  // 0: ready always high, 1: random ready, 2: ready held low
  int rdy_mode = 0;
  initial begin
    forever begin
      @(posedge clk);
      #2;
      case (rdy_mode)
        0: alpha_u_col_tready = 1'b1;
        1: alpha_u_col_tready = ($urandom_range(0, 3) != 0);
        default: alpha_u_col_tready = 1'b0;
      endcase
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_beat(input logic [63:0] d, input logic last, input int gap);
    bit got;
    int n;
    repeat (gap) tick();
    s_tdata  = d;
    s_tlast  = last;
    s_tvalid = 1'b1;
    got = 1'b0;
    n = 0;
    while (!got && n < 2000) begin
      @(negedge clk);
      got = s_tready;
      tick();
      n++;
    end
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    if (!got) chk("accept_timeout", 64'd0, 64'd1);
    else model_accept(d, last);
  endtask

  function automatic logic [63:0] dval(input int idx);
    real r;
    case (idx)
      0:  r = 0.456;
      1:  r = 0.81;
      13: r = 1.0;
      14: r = 0.62;
      27: r = 0.01;
      default: r = 0.05 + 0.03 * idx;
    endcase
    return $realtobits(r);
  endfunction

  task automatic send_frame(input bit with_last);
    for (int i = 0; i < J * I; i++) send_beat(dval(i), with_last && (i == J * I - 1), 0);
  endtask

  // ---------------- output monitor ----------------
  logic            prev_stall = 1'b0;
  logic [J*64-1:0] prev_col;
  logic            prev_tlast;
  logic [EXP_W-1:0] e;

  always @(negedge clk) begin
    if (rst_n) begin
      if (frame_err) fe_seen++;
      if (prev_stall)
        chk("hold", {63'd0, (alpha_u_col !== prev_col) || (alpha_u_col_tlast !== prev_tlast)
                            || !alpha_u_col_tvalid}, 64'd0);
      prev_stall = alpha_u_col_tvalid && !alpha_u_col_tready;
      prev_col   = alpha_u_col;
      prev_tlast = alpha_u_col_tlast;
      if (alpha_u_col_tvalid && alpha_u_col_tready) begin
        if (exp_q.size() == 0) begin
          chk("extra_col", 64'd1, 64'd0);
        end else begin
          e = exp_q.pop_front();
          chk("col_tlast", {63'd0, alpha_u_col_tlast}, {63'd0, e[EXP_W-1]});
          for (int j = 0; j < J; j++)
            chk($sformatf("slot%0d", J - 1 - j), alpha_u_col[j*64 +: 64], e[j*64 +: 64]);
        end
      end
    end else begin
      prev_stall = 1'b0;
    end
  end

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_col"},   {63'd0, alpha_u_col != '0}, 64'd0);
    chk({tag, "_vld"},   {63'd0, alpha_u_col_tvalid}, 64'd0);
    chk({tag, "_last"},  {63'd0, alpha_u_col_tlast}, 64'd0);
    chk({tag, "_ferr"},  {63'd0, frame_err}, 64'd0);
  endtask

  task automatic check_ferr_count(input string tag);
    repeat (3) tick();
    chk(tag, 64'(fe_seen), 64'(fe_exp));
  endtask

  // ---------------- main sequence ----------------
  int t0;
  int wait_n;

  initial begin
    // reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_tready", {63'd0, s_tready}, 64'd1);
    tick();

    // nominal frame, ready high, back-to-back
    t0 = cyc;
    for (int i = 0; i < J * I; i++) begin
      send_beat(dval(i), i == J * I - 1, 0);
      if (i == J - 2) chk("col0_early", {63'd0, alpha_u_col_tvalid}, 64'd0);
      if (i == J - 1) begin
        chk("col0_vld",  {63'd0, alpha_u_col_tvalid}, 64'd1);
        chk("col0_last", {63'd0, alpha_u_col_tlast}, 64'd0);
        chk("col0_lsb",  alpha_u_col[63:0], 64'h3FF0000000000000);
      end
    end
    chk("b2b_cycles", 64'(cyc - t0), 64'(J * I));
    chk("col1_last", {63'd0, alpha_u_col_tlast}, 64'd1);
    check_ferr_count("ferr_nominal");

    // downstream stall across column boundary
    rdy_mode = 2;
    tick();
    for (int i = 0; i < J; i++) send_beat(dval(i), 1'b0, 0);
    for (int i = J; i < 2 * J - 1; i++) send_beat(dval(i), 1'b0, 0);
    @(negedge clk);
    chk("stall_tready", {63'd0, s_tready}, 64'd0);
    chk("stall_vld",    {63'd0, alpha_u_col_tvalid}, 64'd1);
    tick();
    repeat (6) tick();
    rdy_mode = 0;
    send_beat(dval(2 * J - 1), 1'b1, 0);
    chk("stall_col1_vld",  {63'd0, alpha_u_col_tvalid}, 64'd1);
    chk("stall_col1_last", {63'd0, alpha_u_col_tlast}, 64'd1);
    check_ferr_count("ferr_stall");

    // early tlast on 5th double
    for (int i = 0; i < 4; i++) send_beat(dval(i), 1'b0, 0);
    send_beat(dval(4), 1'b1, 0);
    chk("early_ferr",  {63'd0, frame_err}, 64'd1);
    chk("early_novld", {63'd0, alpha_u_col_tvalid}, 64'd0);
    tick();
    chk("early_ferr_pulse", {63'd0, frame_err}, 64'd0);
    send_frame(1'b1);
    check_ferr_count("ferr_early");

    // missing tlast
    send_frame(1'b0);
    chk("miss_ferr", {63'd0, frame_err}, 64'd1);
    chk("miss_vld",  {63'd0, alpha_u_col_tvalid}, 64'd1);
    chk("miss_last", {63'd0, alpha_u_col_tlast}, 64'd1);
    check_ferr_count("ferr_missing");

    // reset mid-column
    for (int i = 0; i < 7; i++) send_beat(dval(i), 1'b0, 0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midrst");
    m_k = 0;
    m_c = 0;
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    chk("midrst_tready", {63'd0, s_tready}, 64'd1);
    tick();
    send_frame(1'b1);
    check_ferr_count("ferr_midrst");

    // random soak
    rdy_mode = 1;
    for (int f = 0; f < 1000; f++) begin
      for (int i = 0; i < J * I; i++)
        send_beat({$urandom, $urandom}, i == J * I - 1,
                  ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0);
    end
    rdy_mode = 0;
    wait_n = 0;
    while (exp_q.size() != 0 && wait_n < 200) begin
      tick();
      wait_n++;
    end
    chk("drain", 64'(exp_q.size()), 64'd0);
    check_ferr_count("ferr_random");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
